// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch-queue entry record and PC alignment helper.
package riscv_if_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } if_entry_t;

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction memory, redirect and decode sides.
// master = fetch stage, slave = surrounding pipeline / memory.
interface if_stage_if;
  import riscv_if_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;

  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_target,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_target,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc
  );

endinterface

// File: rtl/if_stage_fifo.sv
// In-order fetch queue: entries are allocated at request time and
// filled in order as responses return, then popped from the head.
module if_fifo
  import riscv_if_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_data_i,
  input  logic            pop_i,
  output if_entry_t       head_o,
  output logic [CW-1:0]   count_o,
  output logic [CW-1:0]   unfilled_o
);

  if_entry_t ent_q [DEPTH];
  if_entry_t ent_d [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] fptr_q, fptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] unf_q, unf_d;
  logic          fill_ok;

  // A response with nothing outstanding has no entry to land in.
  assign fill_ok = fill_i & (unf_q != '0);

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    fptr_d  = fptr_q;
    count_d = count_q + CW'(alloc_i) - CW'(pop_i);
    unf_d   = unf_q + CW'(alloc_i) - CW'(fill_ok);
    if (alloc_i) begin
      ent_d[tail_q].pc     = alloc_pc_i;
      ent_d[tail_q].instr  = '0;
      ent_d[tail_q].filled = 1'b0;
      tail_d = tail_q + PW'(1);
    end
    if (fill_ok) begin
      ent_d[fptr_q].instr  = fill_data_i;
      ent_d[fptr_q].filled = 1'b1;
      fptr_d = fptr_q + PW'(1);
    end
    if (pop_i) begin
      ent_d[head_q].filled = 1'b0;
      head_d = head_q + PW'(1);
    end
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].filled = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      fptr_d  = '0;
      count_d = '0;
      unf_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      fptr_q  <= '0;
      count_q <= '0;
      unf_q   <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      fptr_q  <= fptr_d;
      count_q <= count_d;
      unf_q   <= unf_d;
    end
  end

  assign head_o     = ent_q[head_q];
  assign count_o    = count_q;
  assign unfilled_o = unf_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC mux, request credit, redirect
// squashing via a discard counter, and the in-order fetch queue.
module if_stage
  import riscv_if_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcNext,
  if_stage_if.master      bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] count;
  logic [CW-1:0] unfilled;
  logic [CW:0]   inflight;
  logic [CW:0]   outst;
  if_entry_t     head;

  logic credit;
  logic accept;
  logic redir_sel;
  logic rsp_drop;
  logic rsp_hit;
  logic fill;
  logic pop;

  // Queue slots and squashed requests both consume credit.
  assign inflight = {1'b0, count} + {1'b0, disc_q};
  assign credit   = inflight < (CW+1)'(DEPTH);

  assign bus.imem_req_valid = ~reset & ~bus.redirect_valid & credit;
  assign bus.imem_req_addr  = align_pc(pc);

  assign accept    = bus.imem_req_valid & bus.imem_req_ready;
  assign redir_sel = ~reset & bus.redirect_valid;

  assign rsp_drop = bus.imem_rsp_valid & (disc_q != '0);
  assign fill     = bus.imem_rsp_valid & (disc_q == '0)
                  & ~bus.redirect_valid;

  assign outst   = {1'b0, unfilled} + {1'b0, disc_q};
  assign rsp_hit = bus.imem_rsp_valid & (outst != '0);

  assign bus.id_valid = ~reset & ~bus.redirect_valid
                      & (count != '0) & head.filled;
  assign bus.id_instr = head.instr;
  assign bus.id_pc    = head.pc;

  assign pop = bus.id_valid & bus.id_ready;

  always_comb begin
    pcNext = pc;
    unique case (1'b1)
      reset:     pcNext = RESET_PC;
      redir_sel: pcNext = align_pc(bus.redirect_target);
      accept:    pcNext = pc + XLEN'(INSTR_BYTES);
      default:   pcNext = pc;
    endcase
  end

  // Everything still owed by memory becomes a discard on redirect,
  // minus the response that lands in the redirect cycle itself.
  always_comb begin
    disc_d = disc_q;
    if (bus.redirect_valid) begin
      disc_d = CW'(outst - {{CW{1'b0}}, rsp_hit});
    end else if (rsp_drop) begin
      disc_d = disc_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disc_q <= '0;
    end else begin
      disc_q <= disc_d;
    end
  end

  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .flush_i     (bus.redirect_valid),
    .alloc_i     (accept),
    .alloc_pc_i  (pc),
    .fill_i      (fill),
    .fill_data_i (bus.imem_rsp_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .unfilled_o  (unfilled)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a PC register and in-order memory model.
module tb_if_stage;
  import riscv_if_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pcNext;

  if_stage_if bus ();

  if_stage #(
    .DEPTH    (2),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pc     (pc),
    .pcNext (pcNext),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc_n = 0;
  int lat = 1;
  int nreq = 0;
  int nreq0;

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;

  mreq_t mq[$];

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string t, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", t, obs, exp);
    end
  endtask

  task automatic exp_req(input string t, input logic v,
                         input logic [31:0] a);
    chk({t, ".req_valid"}, {31'b0, bus.imem_req_valid}, {31'b0, v});
    if (v) chk({t, ".req_addr"}, bus.imem_req_addr, a);
  endtask

  task automatic exp_id(input string t, input logic v,
                        input logic [31:0] p);
    chk({t, ".id_valid"}, {31'b0, bus.id_valid}, {31'b0, v});
    if (v) begin
      chk({t, ".id_pc"}, bus.id_pc, p);
      chk({t, ".id_instr"}, bus.id_instr, f(p));
    end
  endtask

  // One clock: PC register load plus the memory model.
  task automatic step();
    logic        acc;
    logic [31:0] aa;
    logic [31:0] nx;
    logic        rw;
    acc = bus.imem_req_valid & bus.imem_req_ready;
    aa  = bus.imem_req_addr;
    nx  = pcNext;
    rw  = reset;
    @(posedge clk);
    #1;
    pc = nx;
    if (rw) mq.delete();
    else if (acc) begin
      mq.push_back('{a: aa, due: cyc_n + lat});
      nreq++;
    end
    cyc_n++;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc_n) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = f(mq[0].a);
      void'(mq.pop_front());
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    bus.imem_req_ready  = 1'b1;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.id_ready        = 1'b1;
    reset = 1'b1;
    pc    = 32'hDEAD_BEE0;
    #1;
    chk("rst.pcNext", pcNext, 32'h0);
    exp_req("rst", 1'b0, 32'h0);
    exp_id("rst", 1'b0, 32'h0);
    step();
    step();
    reset = 1'b0;
    #1;

    // streaming, 1-cycle memory
    exp_req("A0", 1'b1, 32'h0);
    chk("A0.pcNext", pcNext, 32'h4);
    exp_id("A0", 1'b0, 32'h0);
    step();
    exp_req("A1", 1'b1, 32'h4);
    chk("A1.pcNext", pcNext, 32'h8);
    exp_id("A1", 1'b0, 32'h0);
    step();
    exp_req("A2", 1'b0, 32'h0);
    chk("A2.pcNext", pcNext, 32'h8);
    exp_id("A2", 1'b1, 32'h0);
    step();
    exp_req("A3", 1'b1, 32'h8);
    chk("A3.pcNext", pcNext, 32'hC);
    exp_id("A3", 1'b1, 32'h4);
    step();
    exp_req("A4", 1'b1, 32'hC);
    exp_id("A4", 1'b0, 32'h0);
    step();
    exp_req("A5", 1'b0, 32'h0);
    exp_id("A5", 1'b1, 32'h8);
    step();
    exp_req("A6", 1'b1, 32'h10);
    exp_id("A6", 1'b1, 32'hC);
    step();

    // decode stall
    bus.id_ready = 1'b0;
    do_reset();
    nreq0 = nreq;
    exp_req("B0", 1'b1, 32'h0);
    step();
    exp_req("B1", 1'b1, 32'h4);
    step();
    exp_req("B2", 1'b0, 32'h0);
    exp_id("B2", 1'b1, 32'h0);
    step();
    step();
    step();
    chk("B5.nreq", nreq - nreq0, 2);
    chk("B5.pcNext", pcNext, 32'h8);
    exp_req("B5", 1'b0, 32'h0);
    exp_id("B5", 1'b1, 32'h0);
    step();
    bus.id_ready = 1'b1;
    #1;
    exp_id("B6", 1'b1, 32'h0);
    exp_req("B6", 1'b0, 32'h0);
    step();
    exp_req("B7", 1'b1, 32'h8);
    exp_id("B7", 1'b1, 32'h4);
    step();
    exp_req("B8", 1'b1, 32'hC);
    exp_id("B8", 1'b0, 32'h0);
    step();
    exp_id("B9", 1'b1, 32'h8);
    step();

    // redirect with two requests in flight
    lat = 3;
    do_reset();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h10;
    #1;
    exp_req("C0", 1'b0, 32'h0);
    chk("C0.pcNext", pcNext, 32'h10);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    exp_req("C1", 1'b1, 32'h10);
    step();
    exp_req("C2", 1'b1, 32'h14);
    step();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h203;
    #1;
    chk("C3.pcNext", pcNext, 32'h200);
    exp_req("C3", 1'b0, 32'h0);
    exp_id("C3", 1'b0, 32'h0);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    exp_req("C4", 1'b0, 32'h0);
    exp_id("C4", 1'b0, 32'h0);
    step();
    exp_req("C5", 1'b1, 32'h200);
    exp_id("C5", 1'b0, 32'h0);
    step();
    exp_req("C6", 1'b1, 32'h204);
    exp_id("C6", 1'b0, 32'h0);
    step();
    exp_id("C7", 1'b0, 32'h0);
    step();
    exp_id("C8", 1'b0, 32'h0);
    step();
    exp_id("C9", 1'b1, 32'h200);
    step();

    // redirect coinciding with a response
    lat = 2;
    do_reset();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h40;
    #1;
    chk("D0.pcNext", pcNext, 32'h40);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    exp_req("D1", 1'b1, 32'h40);
    step();
    exp_req("D2", 1'b1, 32'h44);
    step();
    chk("D3.rsp", {31'b0, bus.imem_rsp_valid}, 32'h1);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h80;
    #1;
    chk("D3.pcNext", pcNext, 32'h80);
    exp_id("D3", 1'b0, 32'h0);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    exp_req("D4", 1'b1, 32'h80);
    exp_id("D4", 1'b0, 32'h0);
    step();
    exp_req("D5", 1'b1, 32'h84);
    exp_id("D5", 1'b0, 32'h0);
    step();
    exp_req("D6", 1'b0, 32'h0);
    exp_id("D6", 1'b0, 32'h0);
    step();
    exp_id("D7", 1'b1, 32'h80);
    step();

    // address wrap, plus stray responses
    lat = 1;
    do_reset();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFF;
    bus.imem_rsp_valid  = 1'b1;
    bus.imem_rsp_data   = 32'h1234_5678;
    #1;
    chk("E0.pcNext", pcNext, 32'hFFFF_FFFC);
    exp_req("E0", 1'b0, 32'h0);
    step();
    bus.redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h1234_5678;
    #1;
    exp_req("E1", 1'b1, 32'hFFFF_FFFC);
    chk("E1.pcNext", pcNext, 32'h0);
    step();
    exp_req("E2", 1'b1, 32'h0);
    chk("E2.pcNext", pcNext, 32'h4);
    exp_id("E2", 1'b0, 32'h0);
    step();
    exp_id("E3", 1'b1, 32'hFFFF_FFFC);
    exp_req("E3", 1'b0, 32'h0);
    step();

    // reset with full queue and two in flight
    lat = 3;
    bus.id_ready = 1'b0;
    do_reset();
    exp_req("F0", 1'b1, 32'h0);
    step();
    exp_req("F1", 1'b1, 32'h4);
    step();
    exp_req("F2", 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    chk("F2.pcNext", pcNext, 32'h0);
    exp_req("F2r", 1'b0, 32'h0);
    exp_id("F2r", 1'b0, 32'h0);
    step();
    exp_req("F3", 1'b0, 32'h0);
    exp_id("F3", 1'b0, 32'h0);
    step();
    reset = 1'b0;
    lat = 1;
    #1;
    exp_req("F4", 1'b1, 32'h0);
    chk("F4.pcNext", pcNext, 32'h4);
    exp_id("F4", 1'b0, 32'h0);
    step();
    exp_req("F5", 1'b1, 32'h4);
    exp_id("F5", 1'b0, 32'h0);
    step();
    exp_id("F6", 1'b1, 32'h0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
